// File: rtl/draw_missiles_multi_if.sv
// VGA timing/colour stream through the missile overlay stage.
// The *_in side comes from upstream, and the *_out side is the same stream delayed one pclk.
interface draw_missiles_multi_if;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
  );
endinterface

// File: rtl/draw_missiles_multi.sv
// Multi-slot missile control and overlay: fire handling, cooldown, per-frame motion,
// retirement, and drawing every active missile onto the VGA stream with one pclk of latency.
module draw_missiles_multi #(
  parameter int          N_MISSILES      = 4,
  parameter int          MISSILE_W       = 4,
  parameter int          MISSILE_H       = 16,
  parameter int          SPEED           = 8,
  parameter int          Y_START         = 680,
  parameter int          X_OFFSET        = 30,
  parameter int          H_ACTIVE        = 1024,
  parameter int          COOLDOWN_FRAMES = 8,
  parameter logic [11:0] COLOR           = 12'hF00
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  fire,
  input  logic [11:0]           xpos,
  draw_missiles_multi_if.slave  vga,
  output logic [N_MISSILES-1:0] active_mask,
  output logic                  shot_pulse
);
  localparam logic [10:0] SPEED_L   = 11'(SPEED);
  localparam logic [10:0] Y_START_L = 11'(Y_START);
  localparam logic [11:0] X_OFF_L   = 12'(X_OFFSET);
  localparam logic [11:0] X_MAX_L   = 12'(H_ACTIVE - MISSILE_W);
  localparam logic [11:0] W_M1_L    = 12'(MISSILE_W - 1);
  localparam logic [11:0] H_M1_L    = 12'(MISSILE_H - 1);
  localparam logic [15:0] CD_LOAD   = 16'(COOLDOWN_FRAMES);

  logic                  vblnk_prev;
  logic                  fire_prev;
  logic                  pending;
  logic [15:0]           cooldown;
  logic [N_MISSILES-1:0] active;
  logic [10:0]           slot_x [N_MISSILES];
  logic [10:0]           slot_y [N_MISSILES];

  logic                  frame_tick;
  logic                  fire_edge;
  logic                  spawn;
  logic [N_MISSILES-1:0] free_oh;
  logic [N_MISSILES-1:0] hit;
  logic [11:0]           spawn_x_raw;
  logic [10:0]           spawn_x;
  logic [11:0]           hc12;
  logic [11:0]           vc12;

  assign frame_tick = vga.vblnk_in & ~vblnk_prev;
  assign fire_edge  = fire & ~fire_prev;

  // Lowest clear bit of the pre-tick mask; all zeros when every slot is busy.
  assign free_oh = ~active & (active + N_MISSILES'(1));

  // A fire edge landing on the tick itself is served by that tick.
  assign spawn = frame_tick & (pending | fire_edge) & (cooldown == 16'd0) & (|free_oh);

  assign spawn_x_raw = {1'b0, xpos[10:0]} + X_OFF_L;
  assign spawn_x     = (spawn_x_raw > X_MAX_L) ? X_MAX_L[10:0] : spawn_x_raw[10:0];

  assign hc12 = {1'b0, vga.hcount_in};
  assign vc12 = {1'b0, vga.vcount_in};

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_MISSILES; i++) begin
      hit[i] = active[i]
             && (hc12 >= {1'b0, slot_x[i]}) && (hc12 <= {1'b0, slot_x[i]} + W_M1_L)
             && (vc12 >= {1'b0, slot_y[i]}) && (vc12 <= {1'b0, slot_y[i]} + H_M1_L);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev     <= 1'b0;
      fire_prev      <= 1'b0;
      pending        <= 1'b0;
      cooldown       <= '0;
      active         <= '0;
      shot_pulse     <= 1'b0;
      for (int i = 0; i < N_MISSILES; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
      vga.hcount_out <= '0;
      vga.vcount_out <= '0;
      vga.hsync_out  <= 1'b0;
      vga.vsync_out  <= 1'b0;
      vga.hblnk_out  <= 1'b0;
      vga.vblnk_out  <= 1'b0;
      vga.rgb_out    <= '0;
    end else begin
      vblnk_prev <= vga.vblnk_in;
      fire_prev  <= fire;
      pending    <= frame_tick ? 1'b0 : (pending | fire_edge);
      shot_pulse <= spawn;

      // Slot state only moves during vblank, so a frame is never drawn half-updated.
      if (frame_tick) begin
        if (spawn) begin
          cooldown <= CD_LOAD;
        end else if (cooldown != 16'd0) begin
          cooldown <= cooldown - 16'd1;
        end
        for (int i = 0; i < N_MISSILES; i++) begin
          if (spawn && free_oh[i]) begin
            active[i] <= 1'b1;
            slot_x[i] <= spawn_x;
            slot_y[i] <= Y_START_L;
          end else if (active[i]) begin
            if (slot_y[i] < SPEED_L) begin
              active[i] <= 1'b0;
            end else begin
              slot_y[i] <= slot_y[i] - SPEED_L;
            end
          end
        end
      end

      vga.hcount_out <= vga.hcount_in;
      vga.vcount_out <= vga.vcount_in;
      vga.hsync_out  <= vga.hsync_in;
      vga.vsync_out  <= vga.vsync_in;
      vga.hblnk_out  <= vga.hblnk_in;
      vga.vblnk_out  <= vga.vblnk_in;
      vga.rgb_out    <= ((|hit) && !vga.hblnk_in && !vga.vblnk_in) ? COLOR : vga.rgb_in;
    end
  end

  assign active_mask = active;
endmodule

// File: tb/tb_draw_missiles_multi.sv
// Directed bench for draw_missiles_multi: pixel/timing vector table plus hand-written
// multi-frame sequences for spawn, cooldown, slot exhaustion, retirement, clamping and reset.
module tb_draw_missiles_multi;
  localparam int N = 4;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic [11:0] rgb;
    logic        hit;
  } vec_t;

  logic         pclk = 1'b0;
  logic         rst;
  logic         fire;
  logic [11:0]  xpos;
  logic [N-1:0] active_mask;
  logic         shot_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs [8];

  draw_missiles_multi_if vif ();

  draw_missiles_multi #(.N_MISSILES(N)) dut (
    .pclk        (pclk),
    .rst         (rst),
    .fire        (fire),
    .xpos        (xpos),
    .vga         (vif),
    .active_mask (active_mask),
    .shot_pulse  (shot_pulse)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_vga(input logic [10:0] h, input logic [10:0] v, input logic hs,
                         input logic vs, input logic hb, input logic vb, input logic [11:0] c);
    vif.hcount_in = h;
    vif.vcount_in = v;
    vif.hsync_in  = hs;
    vif.vsync_in  = vs;
    vif.hblnk_in  = hb;
    vif.vblnk_in  = vb;
    vif.rgb_in    = c;
  endtask

  task automatic probe(input string name, input logic [10:0] h, input logic [10:0] v,
                       input logic exp_hit);
    set_vga(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A3);
    cyc();
    check(name, vif.rgb_out, exp_hit ? 32'hF00 : 32'h5A3);
  endtask

  // One frame boundary: vblnk rises for a cycle (optionally with fire), then drops.
  task automatic do_tick(input logic f, output logic pulse, output logic [N-1:0] mask);
    vif.vblnk_in = 1'b1;
    fire         = f;
    cyc();
    pulse        = shot_pulse;
    mask         = active_mask;
    fire         = 1'b0;
    vif.vblnk_in = 1'b0;
    cyc();
  endtask

  task automatic run_table(input logic armed);
    for (int i = 0; i < 8; i++) begin
      set_vga(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].hb, 1'b0, vecs[i].rgb);
      cyc();
      check($sformatf("vec%0d_rgb_armed%0d", i, armed), vif.rgb_out,
            (armed && vecs[i].hit) ? 32'hF00 : {20'd0, vecs[i].rgb});
      check($sformatf("vec%0d_hcount", i), vif.hcount_out, vecs[i].h);
      check($sformatf("vec%0d_vcount", i), vif.vcount_out, vecs[i].v);
      check($sformatf("vec%0d_sync_blank", i),
            {vif.hsync_out, vif.vsync_out, vif.hblnk_out, vif.vblnk_out},
            {vecs[i].hs, vecs[i].vs, vecs[i].hb, 1'b0});
    end
  endtask

  logic         p;
  logic [N-1:0] m;
  logic         fire_t;
  logic         exp_p;
  logic [N-1:0] exp_m;

  initial begin
    vecs[0] = '{11'd530,  11'd680, 1'b1, 1'b0, 1'b0, 12'h123, 1'b1};
    vecs[1] = '{11'd533,  11'd695, 1'b0, 1'b1, 1'b0, 12'h456, 1'b1};
    vecs[2] = '{11'd529,  11'd680, 1'b1, 1'b1, 1'b0, 12'h789, 1'b0};
    vecs[3] = '{11'd534,  11'd680, 1'b0, 1'b0, 1'b0, 12'hABC, 1'b0};
    vecs[4] = '{11'd530,  11'd679, 1'b1, 1'b0, 1'b0, 12'hDEF, 1'b0};
    vecs[5] = '{11'd530,  11'd696, 1'b0, 1'b1, 1'b0, 12'h111, 1'b0};
    vecs[6] = '{11'd531,  11'd690, 1'b1, 1'b1, 1'b1, 12'h222, 1'b0};
    vecs[7] = '{11'd1023, 11'd767, 1'b0, 1'b0, 1'b0, 12'h333, 1'b0};

    // Reset with busy inputs: every output must read zero.
    rst  = 1'b1;
    fire = 1'b0;
    xpos = 12'd0;
    set_vga(11'd100, 11'd200, 1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF);
    repeat (4) cyc();
    check("rst_rgb", vif.rgb_out, 0);
    check("rst_hcount", vif.hcount_out, 0);
    check("rst_vcount", vif.vcount_out, 0);
    check("rst_sync_blank", {vif.hsync_out, vif.vsync_out, vif.hblnk_out, vif.vblnk_out}, 0);
    check("rst_mask", active_mask, 0);
    check("rst_pulse", shot_pulse, 0);
    rst = 1'b0;

    // Two idle frames, then pass-through with nothing in flight.
    for (int f = 0; f < 2; f++) begin
      do_tick(1'b0, p, m);
      check($sformatf("idle%0d_pulse", f), p, 0);
      check($sformatf("idle%0d_mask", f), m, 0);
    end
    run_table(1'b0);

    // Mid-frame fire is held until the next tick and spawns at x=530 y=680.
    xpos = 12'd500;
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    cyc();
    check("pending_no_early_pulse", shot_pulse, 0);
    do_tick(1'b0, p, m);
    check("spawn_pulse", p, 1);
    check("spawn_mask", m, 1);
    check("pulse_one_cycle", shot_pulse, 0);
    run_table(1'b1);
    do_tick(1'b1, p, m);
    check("cooldown_refuse_pulse", p, 0);
    check("cooldown_refuse_mask", m, 1);
    probe("y672_top", 11'd530, 11'd672, 1'b1);
    probe("y672_bottom", 11'd530, 11'd687, 1'b1);
    probe("y672_below", 11'd530, 11'd688, 1'b0);
    probe("y672_above", 11'd530, 11'd671, 1'b0);

    // Fire on every tick (coincident with the vblnk rise) through slot exhaustion,
    // then let slot0 retire and refill it with a clamped spawn.
    rst = 1'b1;
    cyc();
    cyc();
    rst  = 1'b0;
    xpos = 12'd100;
    for (int t = 0; t <= 87; t++) begin
      if (t == 87) xpos = 12'd1020;
      fire_t = (t <= 45) || (t == 86) || (t == 87);
      exp_p  = (t == 0) || (t == 9) || (t == 18) || (t == 27) || (t == 87);
      exp_m  = (t < 9) ? 4'h1 : (t < 18) ? 4'h3 : (t < 27) ? 4'h7 : (t == 86) ? 4'hE : 4'hF;
      do_tick(fire_t, p, m);
      check($sformatf("t%0d_pulse", t), p, exp_p);
      check($sformatf("t%0d_mask", t), m, exp_m);
      if (t == 85) begin
        probe("y0_top", 11'd130, 11'd0, 1'b1);
        probe("y0_bottom", 11'd130, 11'd15, 1'b1);
        probe("y0_below", 11'd130, 11'd16, 1'b0);
        probe("y0_right", 11'd134, 11'd0, 1'b0);
      end
      if (t == 86) probe("retired_gone", 11'd130, 11'd0, 1'b0);
      if (t == 87) begin
        probe("clamp_left", 11'd1020, 11'd680, 1'b1);
        probe("clamp_corner", 11'd1023, 11'd695, 1'b1);
        probe("clamp_outside", 11'd1019, 11'd680, 1'b0);
        set_vga(11'd1021, 11'd685, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0C0);
        cyc();
        check("hblank_no_draw", vif.rgb_out, 12'h0C0);
      end
    end

    // Tick 88 with the beam parked on the missile: vblank must suppress drawing.
    set_vga(11'd1021, 11'd685, 1'b0, 1'b0, 1'b0, 1'b1, 12'h777);
    cyc();
    check("vblank_no_draw", vif.rgb_out, 12'h777);
    check("vblnk_out", vif.vblnk_out, 1);
    check("t88_mask", active_mask, 4'hF);
    vif.vblnk_in = 1'b0;
    cyc();
    for (int t = 89; t <= 95; t++) do_tick(1'b0, p, m);
    check("t95_mask", m, 4'hD);

    // Reset with three missiles in flight clears them on the next edge.
    probe("pre_rst_hit", 11'd1020, 11'd616, 1'b1);
    rst = 1'b1;
    cyc();
    check("midflight_rst_mask", active_mask, 0);
    check("midflight_rst_rgb", vif.rgb_out, 0);
    check("midflight_rst_pulse", shot_pulse, 0);
    rst = 1'b0;
    probe("post_rst_gone", 11'd1020, 11'd616, 1'b0);
    check("post_rst_mask", active_mask, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
